// File: rtl/ft_div_check_seq.sv
// ft_div_check_seq: issues one operand pair per start to the shared divider,
// waits for the decoded channel result, and keeps per-channel hit, invalid
// and timeout statistics with sticky per-channel fault flags.
module ft_div_check_seq #(
   parameter int unsigned THRESH  = 3,
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [31:0]      dividend_i,
   input  logic [31:0]      divisor_i,
   input  logic             clr_fault,
   output logic [31:0]      dividend_tdata,
   output logic             dividend_tvalid,
   input  logic             dividend_tready,
   output logic [31:0]      divisor_tdata,
   output logic             divisor_tvalid,
   input  logic             divisor_tready,
   input  logic [8:0]       judge_result,
   input  logic             judge_result_en,
   output logic             busy,
   output logic             done,
   output logic [8:0]       last_result,
   output logic [7:0]       fault_vec,
   output logic [CNT_W-1:0] invalid_cnt,
   output logic [CNT_W-1:0] timeout_cnt
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned RES_W  = 9;
   localparam int unsigned NCH    = 8;
   localparam int unsigned HIT_W  = 8;
   localparam int unsigned TMR_W  = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t              r_state;
   logic [TMR_W-1:0]    r_timer;
   logic [DATA_W-1:0]   r_dvd_data;
   logic [DATA_W-1:0]   r_dvs_data;
   logic                r_dvd_valid;
   logic                r_dvs_valid;
   logic                r_busy;
   logic                r_done;
   logic [RES_W-1:0]    r_last;
   logic [NCH-1:0]      r_fault;
   logic [CNT_W-1:0]    r_inv;
   logic [CNT_W-1:0]    r_tmo;
   logic [HIT_W-1:0]    r_hit [NCH];

   state_t              w_state_nxt;
   logic [TMR_W-1:0]    w_timer_nxt;
   logic [DATA_W-1:0]   w_dvd_data_nxt;
   logic [DATA_W-1:0]   w_dvs_data_nxt;
   logic                w_dvd_valid_nxt;
   logic                w_dvs_valid_nxt;
   logic                w_busy_nxt;
   logic                w_done_nxt;
   logic [RES_W-1:0]    w_last_nxt;
   logic [NCH-1:0]      w_fault_nxt;
   logic [CNT_W-1:0]    w_inv_nxt;
   logic [CNT_W-1:0]    w_tmo_nxt;
   logic [HIT_W-1:0]    w_hit_nxt [NCH];

   logic                w_dvd_pend;
   logic                w_dvs_pend;
   logic                w_onehot;

   // A channel stays pending until its own valid/ready handshake
   assign w_dvd_pend = r_dvd_valid & ~dividend_tready;
   assign w_dvs_pend = r_dvs_valid & ~divisor_tready;
   assign w_onehot   = $onehot(judge_result[NCH-1:0]) & ~judge_result[NCH];

   // Next-state and next-output computation
   always_comb begin
      w_state_nxt     = r_state;
      w_timer_nxt     = r_timer;
      w_dvd_data_nxt  = r_dvd_data;
      w_dvs_data_nxt  = r_dvs_data;
      w_dvd_valid_nxt = r_dvd_valid;
      w_dvs_valid_nxt = r_dvs_valid;
      w_busy_nxt      = r_busy;
      w_done_nxt      = 1'b0;
      w_last_nxt      = r_last;
      w_fault_nxt     = r_fault;
      w_inv_nxt       = r_inv;
      w_tmo_nxt       = r_tmo;
      for (int k = 0; k < int'(NCH); k++) begin
         w_hit_nxt[k] = r_hit[k];
      end

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_dvd_data_nxt  = dividend_i;
               w_dvs_data_nxt  = divisor_i;
               w_dvd_valid_nxt = 1'b1;
               w_dvs_valid_nxt = 1'b1;
               w_busy_nxt      = 1'b1;
               w_state_nxt     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_dvd_valid_nxt = w_dvd_pend;
            w_dvs_valid_nxt = w_dvs_pend;
            if (!w_dvd_pend && !w_dvs_pend) begin
               w_state_nxt = S_WAIT;
               w_timer_nxt = '0;
            end
         end
         S_WAIT: begin
            if (judge_result_en) begin
               w_last_nxt  = judge_result;
               w_done_nxt  = 1'b1;
               w_busy_nxt  = 1'b0;
               w_state_nxt = S_IDLE;
               if (w_onehot) begin
                  for (int k = 0; k < int'(NCH); k++) begin
                     if (judge_result[k]) begin
                        if (r_hit[k] != HIT_W'(THRESH)) begin
                           w_hit_nxt[k] = r_hit[k] + HIT_W'(1);
                        end
                        if (w_hit_nxt[k] == HIT_W'(THRESH)) begin
                           w_fault_nxt[k] = 1'b1;
                        end
                     end
                  end
               end else if (r_inv != {CNT_W{1'b1}}) begin
                  w_inv_nxt = r_inv + CNT_W'(1);
               end
            end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
               w_last_nxt  = RES_W'(9'h100);
               w_done_nxt  = 1'b1;
               w_busy_nxt  = 1'b0;
               w_state_nxt = S_IDLE;
               if (r_tmo != {CNT_W{1'b1}}) begin
                  w_tmo_nxt = r_tmo + CNT_W'(1);
               end
            end else begin
               w_timer_nxt = r_timer + TMR_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Clear overrides any statistics update in the same cycle
      if (clr_fault) begin
         w_fault_nxt = '0;
         w_inv_nxt   = '0;
         w_tmo_nxt   = '0;
         for (int k = 0; k < int'(NCH); k++) begin
            w_hit_nxt[k] = '0;
         end
      end
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_timer     <= '0;
         r_dvd_data  <= '0;
         r_dvs_data  <= '0;
         r_dvd_valid <= 1'b0;
         r_dvs_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_last      <= '0;
         r_fault     <= '0;
         r_inv       <= '0;
         r_tmo       <= '0;
         for (int k = 0; k < int'(NCH); k++) begin
            r_hit[k] <= '0;
         end
      end else begin
         r_state     <= w_state_nxt;
         r_timer     <= w_timer_nxt;
         r_dvd_data  <= w_dvd_data_nxt;
         r_dvs_data  <= w_dvs_data_nxt;
         r_dvd_valid <= w_dvd_valid_nxt;
         r_dvs_valid <= w_dvs_valid_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
         r_last      <= w_last_nxt;
         r_fault     <= w_fault_nxt;
         r_inv       <= w_inv_nxt;
         r_tmo       <= w_tmo_nxt;
         for (int k = 0; k < int'(NCH); k++) begin
            r_hit[k] <= w_hit_nxt[k];
         end
      end
   end

   assign dividend_tdata  = r_dvd_data;
   assign dividend_tvalid = r_dvd_valid;
   assign divisor_tdata   = r_dvs_data;
   assign divisor_tvalid  = r_dvs_valid;
   assign busy            = r_busy;
   assign done            = r_done;
   assign last_result     = r_last;
   assign fault_vec       = r_fault;
   assign invalid_cnt     = r_inv;
   assign timeout_cnt     = r_tmo;

endmodule
